fir_decim_sat: RTL and testbench
================================

FIR_DECIM_SAT -- requirements
Module: fir_decim_sat

Interface
REQ-001 Parameter DECIM, default 4: decimation factor; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter SHIFT, default 2: right-shift applied after accumulation; legal range 0..12.
REQ-003 Parameter DEPTH, default 4: output FIFO entries; power of two, 2..16.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Rst  input  1: asynchronous, active-high reset.
REQ-006 Yn  input  16: signed sample from the upstream 8-tap DA FIR.
REQ-007 in_valid  input  1: Yn is a new sample this cycle.
REQ-008 out_data  output  8: signed decimated, rounded and saturated result (FIFO head).
REQ-009 out_valid  output  1: FIFO is not empty.
REQ-010 out_ready  input  1: consumer accepts the head entry this cycle.
REQ-011 ovf  output  1: sticky overrun flag; a result was dropped because the FIFO was full.
REQ-012 sat_count  output  8: saturation event counter; present only with FIRDEC_STATS_EN.

Function
REQ-013 The block SHALL keep a phase counter 0..DECIM-1 that advances only on in_valid and wraps from DECIM-1 to 0.
REQ-014 The block SHALL hold a 20-bit signed accumulator; on in_valid at phase 0 it loads sign-extended Yn, otherwise it adds sign-extended Yn.
REQ-015 On in_valid at phase DECIM-1, the block SHALL form sum = acc + Yn (including the current sample) and produce a result in the same cycle.
REQ-016 Rounding: when SHIFT>0, r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic and round-half-up; when SHIFT=0, r = sum.
REQ-017 Saturation: r>127 SHALL yield 127 and r<-128 SHALL yield -128; otherwise out = r[7:0]; either clamp is a saturation event.
REQ-018 The result SHALL be written to the FIFO on the same rising edge; out_valid SHALL rise on the next cycle (latency 1 clock from the final in_valid).
REQ-019 With DECIM=1, every in_valid SHALL produce a result, and the phase counter stays at 0.
REQ-020 A pop SHALL occur when out_valid and out_ready are both 1; out_data SHALL show the next entry on the following cycle.
REQ-021 While the FIFO is empty, out_valid=0 and out_data=0; out_ready is ignored.
REQ-022 If a push hits a full FIFO with no pop in that cycle, the block SHALL drop the result and set ovf=1 until reset.
REQ-023 If a push and a pop occur in the same cycle while the FIFO is full, the block SHALL accept both; occupancy stays DEPTH and ovf is unchanged.
REQ-024 If a push and a pop occur in the same cycle while the FIFO holds exactly one entry, the block SHALL accept both, keep out_valid=1, and present the new entry.
REQ-025 The FIFO read and write pointers SHALL wrap modulo DEPTH; an occupancy counter of log2(DEPTH)+1 bits drives full and empty.
REQ-026 in_valid SHALL never be back-pressured; the upstream stage has no stall.

Reset
REQ-027 When Rst=1, the block SHALL immediately clear the phase counter, accumulator, FIFO pointers, occupancy, ovf, and sat_count, independent of clk.
REQ-028 While reset is active, out_valid=0 and out_data=0.
REQ-029 When Rst is asserted mid-accumulation, the block SHALL discard the partial sum; the first in_valid after release is phase 0.
REQ-030 Inputs SHALL be ignored while Rst=1; normal operation starts on the first rising edge after Rst deasserts.

Configuration
REQ-031 With the macro FIRDEC_STATS_EN defined, the block SHALL provide port sat_count, which increments by 1 on each saturation event whether or not the result is dropped, and holds at 255.
REQ-032 Without FIRDEC_STATS_EN, port sat_count and its logic SHALL be absent; all other behaviour is identical.

Verification (DECIM=4, SHIFT=2, DEPTH=4 unless stated)
REQ-033 Four in_valid samples of 100 each, out_ready=1 -> one result out_data=100, out_valid high for 1 cycle, one clock after the 4th sample.
REQ-034 Samples 1000 ×4 -> 127; then -1000 ×4 -> -128; with FIRDEC_STATS_EN, sat_count=2.
REQ-035 Rounding: samples 1,1,0,0 -> 1; samples -1,-1,0,0 -> 0; samples -3,0,0,0 -> -1.
REQ-036 out_ready=0 with 5 results generated -> 4 entries held, ovf=1; then out_ready=1 -> first four results pop in order, and out_valid falls after the 4th.
REQ-037 Rst pulsed after 2 of 4 samples, then samples 8,8,8,8 -> result 8 (partial sum discarded); ovf=0, FIFO empty immediately after the pulse.
REQ-038 Full FIFO with simultaneous pop and push -> no drop, ovf stays 0, and the new result appears after the three remaining older entries.

Source files
------------

// File: rtl/fir_decim_sat.sv
// fir_decim_sat: decimating accumulator behind an 8-tap DA FIR.
// It sums DECIM consecutive samples, then rounds, shifts and saturates the
// sum to 8 bits and queues the result in a small output FIFO.
// Optional build macro: FIRDEC_STATS_EN adds the sat_count port and counter.
`timescale 1ns/1ps
module fir_decim_sat #(
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [15:0] Yn,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf
`ifdef FIRDEC_STATS_EN
  ,
  output logic [7:0]  sat_count
`endif
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  logic [PW-1:0]      phase_reg;
  logic signed [19:0] acc_reg;
  logic signed [20:0] sum;      // one guard bit so the rounding add cannot wrap
  logic signed [20:0] rnd;
  logic [7:0]         res;
  logic               sat_evt;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               wr_en;

  logic [7:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      cnt_reg;
  logic               ovf_reg;

  // Running sum including the current sample; phase 0 starts a fresh window.
  always_comb begin
    if (phase_reg == '0)
      sum = {{5{Yn[15]}}, Yn};
    else
      sum = {acc_reg[19], acc_reg} + {{5{Yn[15]}}, Yn};
  end

  // Round-half-up arithmetic shift; SHIFT=0 passes the sum through untouched.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [20:0] HALF = 21'sd1 <<< (SHIFT - 1);
      assign rnd = (sum + HALF) >>> SHIFT;
    end else begin : g_noround
      assign rnd = sum;
    end
  endgenerate

  // Clamp to the signed 8-bit range and flag when a clamp happened.
  always_comb begin
    sat_evt = 1'b0;
    res     = rnd[7:0];
    if (rnd > 21'sd127) begin
      res     = 8'h7F;
      sat_evt = 1'b1;
    end else if (rnd < -21'sd128) begin
      res     = 8'h80;
      sat_evt = 1'b1;
    end
  end

  assign push  = in_valid && (phase_reg == LAST_PHASE);
  assign full  = (cnt_reg == FULL_CNT);
  assign empty = (cnt_reg == '0);
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  // Phase counter and accumulator advance only on accepted samples.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      phase_reg <= '0;
      acc_reg   <= '0;
    end else if (in_valid) begin
      phase_reg <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + 1'b1;
      acc_reg   <= sum[19:0];
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the output.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= res;
  end

  // FIFO pointers, occupancy and the sticky overrun flag.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
      if (push && full && !pop)
        ovf_reg <= 1'b1;
    end
  end

`ifdef FIRDEC_STATS_EN
  logic [7:0] sat_cnt_reg;

  // Saturation counter counts every clamped result, dropped or not, and sticks at 255.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)
      sat_cnt_reg <= '0;
    else if (push && sat_evt && (sat_cnt_reg != 8'hFF))
      sat_cnt_reg <= sat_cnt_reg + 1'b1;
  end

  assign sat_count = sat_cnt_reg;
`else
  logic unused_sat;
  assign unused_sat = sat_evt;
`endif

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rd_ptr_reg];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fir_decim_sat.sv
// tb_fir_decim_sat: scoreboard bench for fir_decim_sat (DECIM=4, SHIFT=2, DEPTH=4).
// Expected results are pushed when the final sample of a window is driven
// and compared when the DUT pops them.
`timescale 1ns/1ps
module tb_fir_decim_sat;

  localparam int DECIM = 4;
  localparam int SHIFT = 2;
  localparam int DEPTH = 4;

  logic        clk;
  logic        Rst;
  logic [15:0] Yn;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
`ifdef FIRDEC_STATS_EN
  logic [7:0]  sat_count;
`endif

  fir_decim_sat #(.DECIM(DECIM), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .Yn        (Yn),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
`ifdef FIRDEC_STATS_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int q[$];
  int m_phase = 0;
  int m_acc   = 0;
  int m_ovf   = 0;
  int m_sat   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock: drive inputs at the falling edge, check outputs, update model.
  task automatic step(input bit iv, input int y, input bit rdy);
    int sum;
    int r;
    in_valid  = iv;
    Yn        = 16'(y);
    out_ready = rdy;
    #1;
    check("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
    if (q.size() == 0)
      check("empty_data", int'(out_data), 0);
    else if (rdy)
      check("pop_data", int'($signed(out_data)), q.pop_front());
    if (iv) begin
      sum = (m_phase == 0) ? y : m_acc + y;
      if (m_phase == DECIM - 1) begin
        r = (sum + (1 << (SHIFT - 1))) >>> SHIFT;
        if (r > 127) begin
          r = 127;
          if (m_sat < 255) m_sat++;
        end else if (r < -128) begin
          r = -128;
          if (m_sat < 255) m_sat++;
        end
        if (q.size() < DEPTH)
          q.push_back(r);
        else
          m_ovf = 1;
        m_phase = 0;
      end else begin
        m_acc = sum;
        m_phase++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("ovf", int'(ovf), m_ovf);
`ifdef FIRDEC_STATS_EN
    check("sat_count", int'(sat_count), m_sat);
`endif
  endtask

  task automatic send4(input int a, input int b, input int c, input int d, input bit rdy);
    step(1'b1, a, rdy);
    step(1'b1, b, rdy);
    step(1'b1, c, rdy);
    step(1'b1, d, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      step(1'b0, 0, rdy);
  endtask

  // Asynchronous reset pulse between clock edges, with junk on the inputs.
  task automatic pulse_reset();
    in_valid = 1'b1;
    Yn       = 16'd5;
    #1 Rst = 1'b1;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_ovf", int'(ovf), 0);
    in_valid = 1'b0;
    #1 Rst = 1'b0;
    #1;
    check("post_rst_valid", int'(out_valid), 0);
    q.delete();
    m_phase = 0;
    m_acc   = 0;
    m_ovf   = 0;
    m_sat   = 0;
    @(negedge clk);
  endtask

  initial begin
    Rst       = 1'b1;
    in_valid  = 1'b0;
    Yn        = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    check("reset_ovf", int'(ovf), 0);
`ifdef FIRDEC_STATS_EN
    check("reset_sat", int'(sat_count), 0);
`endif
    Rst = 1'b0;

    // basic average, result visible one clock after the 4th sample
    send4(100, 100, 100, 100, 1'b1);
    idle(2, 1'b1);

    // saturation both ways
    send4(1000, 1000, 1000, 1000, 1'b1);
    idle(1, 1'b1);
    send4(-1000, -1000, -1000, -1000, 1'b1);
    idle(2, 1'b1);

    // rounding, with gaps between samples
    send4(1, 1, 0, 0, 1'b1);
    idle(1, 1'b1);
    step(1'b1, -1, 1'b1);
    idle(1, 1'b1);
    step(1'b1, -1, 1'b1);
    step(1'b1, 0, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 0, 1'b1);
    idle(1, 1'b1);
    send4(-3, 0, 0, 0, 1'b1);
    idle(2, 1'b1);

    // overrun: five results with no consumer, then drain four in order
    for (int k = 1; k <= 5; k++)
      send4(10 * k, 10 * k, 10 * k, 10 * k, 1'b0);
    idle(6, 1'b1);

    // reset in mid-window discards the partial sum and clears ovf
    step(1'b1, 50, 1'b1);
    step(1'b1, 50, 1'b1);
    pulse_reset();
    send4(8, 8, 8, 8, 1'b1);
    idle(2, 1'b1);

    // full FIFO with simultaneous push and pop: nothing is dropped
    for (int k = 1; k <= 4; k++)
      send4(4 * k, 4 * k, 4 * k, 4 * k, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b1, 20, 1'b1);
    idle(6, 1'b1);

    // single entry with simultaneous push and pop
    send4(-40, -40, -40, -40, 1'b0);
    step(1'b1, 60, 1'b0);
    step(1'b1, 60, 1'b0);
    step(1'b1, 60, 1'b0);
    step(1'b1, 60, 1'b1);
    idle(3, 1'b1);

    // random traffic across the full sample range
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    idle(8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
